systolic3x3_seq: RTL

Sequencer for the 3x3 output-stationary systolic array (systolic3x3).
- Accepts one pair of 3x3 operand matrices through a start/ready handshake.
- Clears the array's accumulators, then streams diagonally skewed rows of A into A0/A3/A6 and skewed columns of B into B0/B1/B2.
- Drains the pipeline, snapshots C0..C8 into a result register, and pulses DONE.
- Sits between the host/buffer logic and the array; it is the only driver of the array's inputs.

---
 rtl/systolic_pkg.sv | 22 ++
 rtl/systolic_skew_lane.sv | 22 ++
 rtl/systolic3x3_seq.sv | 120 ++++++++++++
 3 files changed

// File: rtl/systolic_pkg.sv
// Shared constants, state encoding and matrix helpers for the 3x3 systolic sequencer.
package systolic_pkg;

  localparam int DATA_W   = 32;
  localparam int N        = 3;
  localparam int FEED_LEN = 3 * N - 2;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    FEED,
    CAPTURE,
    DONE
  } seq_state_t;

  // Row-major element (row, col) of a packed 3x3 matrix at the package width.
  function automatic logic [DATA_W-1:0] elem(input logic [9*DATA_W-1:0] mat,
                                             input int row, input int col);
    return mat[(3*row+col)*DATA_W +: DATA_W];
  endfunction

endpackage

// File: rtl/systolic_skew_lane.sv
// One skewed operand lane: emits vec[t-L] while 0 <= t-L <= 2, otherwise zero.
module systolic_skew_lane #(
  parameter int DATA_W = 32,
  parameter int L      = 0
) (
  input  logic [2:0][DATA_W-1:0] vec,
  input  logic [2:0]             t,
  input  logic                   en,
  output logic [DATA_W-1:0]      lane_o
);

  localparam logic [2:0] LANE = 3'(L);

  logic [2:0] idx;

  always_comb begin
    idx    = t - LANE;
    lane_o = '0;
    if (en && (t >= LANE) && (idx <= 3'd2)) lane_o = vec[idx[1:0]];
  end

endmodule

// File: rtl/systolic3x3_seq.sv
// Sequencer for the 3x3 output-stationary systolic array: clear, skewed feed,
// drain, capture the result and pulse DONE.
module systolic3x3_seq #(
  parameter int DATA_W = systolic_pkg::DATA_W,
  parameter int N      = systolic_pkg::N
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  START,
  input  logic [9*DATA_W-1:0]   A_MAT,
  input  logic [9*DATA_W-1:0]   B_MAT,
  output logic                  READY,
  output logic                  DONE,
  output logic [9*DATA_W-1:0]   C_MAT,
  input  logic [9*DATA_W-1:0]   ARR_C,
  output logic [DATA_W-1:0]     ARR_A0,
  output logic [DATA_W-1:0]     ARR_A3,
  output logic [DATA_W-1:0]     ARR_A6,
  output logic [DATA_W-1:0]     ARR_B0,
  output logic [DATA_W-1:0]     ARR_B1,
  output logic [DATA_W-1:0]     ARR_B2,
  output logic                  ARR_EN,
  output logic                  ARR_CLR
);
  import systolic_pkg::*;

  if (N != 3) begin : g_bad_n
    $error("systolic3x3_seq: N must be 3");
  end

  localparam logic [2:0] T_LAST = 3'(FEED_LEN - 1);

  seq_state_t                 state_q, state_d;
  logic [2:0]                 t_q, t_d;
  logic [8:0][DATA_W-1:0]     a_op_q, a_op_d, b_op_q, b_op_d;
  logic [9*DATA_W-1:0]        c_q, c_d;
  logic                       en_q, en_d, clr_q, clr_d, done_q, done_d, feed_d;
  logic [2:0][DATA_W-1:0]     a_lane, b_lane, arr_a_q, arr_b_q;

  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    a_op_d  = a_op_q;
    b_op_d  = b_op_q;
    c_d     = c_q;
    case (state_q)
      IDLE: if (START) begin
        state_d = CLEAR;
        t_d     = '0;
        a_op_d  = A_MAT;
        b_op_d  = B_MAT;
      end
      CLEAR:   state_d = FEED;
      FEED:    if (t_q == T_LAST) state_d = CAPTURE;
               else               t_d     = t_q + 3'd1;
      CAPTURE: begin
        state_d = systolic_pkg::DONE;
        c_d     = ARR_C;
      end
      systolic_pkg::DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Array-facing controls are decoded from the next state so they leave flops.
    feed_d = (state_d == FEED);
    en_d   = (state_d == CLEAR) || feed_d;
    clr_d  = (state_d == CLEAR);
    done_d = (state_d == systolic_pkg::DONE);
  end

  for (genvar r = 0; r < 3; r++) begin : g_lane
    logic [2:0][DATA_W-1:0] a_row, b_col;
    assign a_row = a_op_d[3*r+2 -: 3];
    assign b_col = {b_op_d[r+6], b_op_d[r+3], b_op_d[r]};
    systolic_skew_lane #(.DATA_W(DATA_W), .L(r)) u_a (
      .vec(a_row), .t(t_d), .en(feed_d), .lane_o(a_lane[r])
    );
    systolic_skew_lane #(.DATA_W(DATA_W), .L(r)) u_b (
      .vec(b_col), .t(t_d), .en(feed_d), .lane_o(b_lane[r])
    );
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= IDLE;
      t_q     <= '0;
      a_op_q  <= '0;
      b_op_q  <= '0;
      c_q     <= '0;
      en_q    <= 1'b0;
      clr_q   <= 1'b0;
      done_q  <= 1'b0;
      arr_a_q <= '0;
      arr_b_q <= '0;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      a_op_q  <= a_op_d;
      b_op_q  <= b_op_d;
      c_q     <= c_d;
      en_q    <= en_d;
      clr_q   <= clr_d;
      done_q  <= done_d;
      arr_a_q <= a_lane;
      arr_b_q <= b_lane;
    end
  end

  assign READY   = (state_q == IDLE);
  assign DONE    = done_q;
  assign C_MAT   = c_q;
  assign ARR_EN  = en_q;
  assign ARR_CLR = clr_q;
  assign ARR_A0  = arr_a_q[0];
  assign ARR_A3  = arr_a_q[1];
  assign ARR_A6  = arr_a_q[2];
  assign ARR_B0  = arr_b_q[0];
  assign ARR_B1  = arr_b_q[1];
  assign ARR_B2  = arr_b_q[2];

endmodule
